// File: rtl/core_scoreboard.sv
// In-order register-hazard scoreboard: tracks issued writers until writeback and stalls decode.
// Optional: define CORE_SB_WB_BYPASS_EN to let a retiring head entry stop matching in its retire cycle.
module core_scoreboard #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    rs1,
    input  logic          want_rs1,
    input  logic [4:0]    rs2,
    input  logic          want_rs2,
    input  logic          iss_fire,
    input  logic [4:0]    iss_rd,
    input  logic          iss_wen,
    input  logic          wb_valid,
    input  logic [4:0]    wb_rd,
    input  logic          kill,
    input  logic [AW:0]   kill_cnt,
    output logic          stall,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          err
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [4:0]       rd_q [DEPTH];
    logic [DEPTH-1:0] wen_q;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic             err_q, err_d;

    logic [DEPTH-1:0] vld, hit1, hit2;
    logic             pop, push, push_req, mism;
    logic [AW:0]      avail, kn;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign err   = err_q;

    assign pop      = wb_valid & ~empty;
    assign push_req = iss_fire & ~kill;
    assign push     = push_req & ~full;
    assign mism     = pop & wen_q[head_q] & (wb_rd != rd_q[head_q]);

    always_comb begin
        vld  = '0;
        hit1 = '0;
        hit2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Entry is live when its distance from head is below count.
            vld[i] = {1'b0, AW'(i) - head_q} < count_q;
`ifdef CORE_SB_WB_BYPASS_EN
            if (pop && (AW'(i) == head_q)) vld[i] = 1'b0;
`endif
            hit1[i] = vld[i] & wen_q[i] & (rd_q[i] == rs1) & (rs1 != 5'd0);
            hit2[i] = vld[i] & wen_q[i] & (rd_q[i] == rs2) & (rs2 != 5'd0);
        end
    end

    assign stall = (want_rs1 & |hit1) | (want_rs2 & |hit2) | full;

    always_comb begin
        // Pop removes the oldest first; kill then trims from the youngest.
        avail   = count_q - (AW+1)'(pop);
        kn      = '0;
        if (kill) kn = (kill_cnt < avail) ? kill_cnt : avail;
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push) - kn[AW-1:0];
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop) - kn;
        err_d   = err_q | (push_req & full) | (wb_valid & empty) | mism;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]  <= iss_rd;
            wen_q[tail_q] <= iss_wen;
        end
    end

endmodule
